// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 5-stage pipeline.
//
// This stage takes one instruction at a time from execute through a
// valid/allow_in handshake. A load or store issues exactly one data-SRAM
// request and waits for completion before the stage produces the
// write-back result. The stage also drives forwarding and load-stall
// information back to decode.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   EX_to_MEM_valid        execute holds a valid instruction
//   to_MEM_data            {alu_result, rkd_value, mem_we, res_from_mem, dest, gr_we}
//   MEM_allow_in           stage can accept an instruction this cycle
//   WB_allow_in            write-back can accept
//   MEM_to_WB_valid        valid instruction presented to write-back
//   to_WB_data             {final_result, dest, gr_we}
//   data_sram_*            request/response data-SRAM interface
//   MEM_fwd_valid/dest/result  forwarding information for decode
//   MEM_load_pending       a load is in flight and its data is not yet back
module mem_stage #(
  parameter int TO_MEM_W = 71,
  parameter int TO_WB_W  = 38
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                EX_to_MEM_valid,
  input  logic [TO_MEM_W:0]   to_MEM_data,
  output logic                MEM_allow_in,
  input  logic                WB_allow_in,
  output logic                MEM_to_WB_valid,
  output logic [TO_WB_W-1:0]  to_WB_data,
  output logic                data_sram_req,
  output logic                data_sram_wr,
  output logic [3:0]          data_sram_wstrb,
  output logic [31:0]         data_sram_addr,
  output logic [31:0]         data_sram_wdata,
  input  logic                data_sram_addr_ok,
  input  logic                data_sram_data_ok,
  input  logic [31:0]         data_sram_rdata,
  output logic                MEM_fwd_valid,
  output logic [4:0]          MEM_fwd_dest,
  output logic [31:0]         MEM_fwd_result,
  output logic                MEM_load_pending
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state_reg;
  state_t              state_next;
  logic                mem_valid_reg;
  logic [TO_MEM_W:0]   payload_reg;
  logic [31:0]         load_data_reg;

  // Latched payload fields.
  logic [31:0] alu_result;
  logic [31:0] rkd_value;
  logic        mem_we;
  logic        res_from_mem;
  logic [4:0]  dest;
  logic        gr_we;

  assign alu_result   = payload_reg[71:40];
  assign rkd_value    = payload_reg[39:8];
  assign mem_we       = payload_reg[7];
  assign res_from_mem = payload_reg[6];
  assign dest         = payload_reg[5:1];
  assign gr_we        = payload_reg[0];

  logic        mem_op;
  logic        in_mem_op;
  logic        ready_go;
  logic        accept;
  logic        leave;
  logic [31:0] final_result;

  assign mem_op       = mem_we | res_from_mem;
  // The decision for the next state uses the incoming instruction's type.
  assign in_mem_op    = to_MEM_data[7] | to_MEM_data[6];
  assign ready_go     = ~mem_op | (state_reg == DONE);
  assign leave        = ready_go & WB_allow_in;
  assign MEM_allow_in = ~mem_valid_reg | leave;
  assign accept       = EX_to_MEM_valid & MEM_allow_in;
  assign final_result = res_from_mem ? load_data_reg : alu_result;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_valid_reg <= 1'b0;
      payload_reg   <= '0;
      load_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mem_valid_reg <= 1'b1;
        payload_reg   <= to_MEM_data;
      end else if (leave) begin
        mem_valid_reg <= 1'b0;
      end
      if ((state_reg == WAIT) && data_sram_data_ok) begin
        load_data_reg <= data_sram_rdata;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: state_next = IDLE;
      REQ:  if (data_sram_addr_ok) state_next = WAIT;
      WAIT: if (data_sram_data_ok) state_next = DONE;
      DONE: if (WB_allow_in)       state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // A newly accepted instruction restarts the sequence regardless of
    // where the departing instruction left the FSM.
    if (accept) begin
      state_next = in_mem_op ? REQ : IDLE;
    end
  end

  // Request fields come straight from the latched payload, so they stay
  // stable for as long as the request is held waiting for addr_ok.
  assign data_sram_req   = (state_reg == REQ);
  assign data_sram_wr    = mem_we;
  assign data_sram_wstrb = mem_we ? 4'hF : 4'h0;
  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rkd_value;

  assign MEM_to_WB_valid  = mem_valid_reg & ready_go;
  assign to_WB_data       = {final_result, dest, gr_we};

  assign MEM_fwd_valid    = mem_valid_reg & gr_we & (dest != 5'd0);
  assign MEM_fwd_dest     = dest;
  assign MEM_fwd_result   = final_result;
  assign MEM_load_pending = mem_valid_reg & res_from_mem & (state_reg != DONE);

endmodule
